// File: rtl/pixel_framebuffer.sv
// 1-bpp framebuffer behind the VGA colour stage. Display prefetch and pen RMW writes share one single-port word memory.
// Build option FB_CLEAR_ON_RESET_EN: run a full clear sweep automatically on reset release.
//
// state | meaning
// IDLE  | wr_ready high, waiting for a pen write or clear
// RD    | read target word (waits while hcounter[3:0] is 13 or 14)
// WR    | write back word with the target bit updated
// CLR   | zero one word per cycle, skipping display slots
module pixel_framebuffer #(
   parameter int H_VISIBLE = 640,
   parameter int V_VISIBLE = 480,
   parameter int H_TOTAL   = 800,
   parameter int V_TOTAL   = 525
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [10:0] hcounter,
   input  logic [9:0]  vcounter,
   output logic        pixel,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [9:0]  wr_x,
   input  logic [8:0]  wr_y,
   input  logic        wr_color,
   input  logic        clear_req,
   output logic        clear_busy
);

   localparam int WPL   = H_VISIBLE / 16;
   localparam int DEPTH = WPL * V_VISIBLE;
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_CLR} state_t;

   state_t          state, state_nx;
   logic [9:0]      wx;
   logic [8:0]      wy;
   logic            wc;
   logic            clr_pending;
   logic            clr_done;
   logic            capture;
   logic [AW-1:0]   clr_addr;
   logic [15:0]     cur_word;
   logic [15:0]     mem_q;
   logic            fetch_vis;

   logic [15:0]     mem [0:DEPTH-1];
   logic            mem_re, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [15:0]     mem_wdata;

   logic            slot14, slot15, rd_wait, in_range;
   logic [11:0]     hn_raw, hn;
   logic [9:0]      vn;
   logic            fetch_vis_nx;
   logic [AW-1:0]   disp_addr, rmw_addr;
   logic [15:0]     rmw_word;

   assign slot14   = (hcounter[3:0] == 4'd14);
   assign slot15   = (hcounter[3:0] == 4'd15);
   assign rd_wait  = (hcounter[3:0] == 4'd13) || slot14;
   assign in_range = (wr_x < 10'(H_VISIBLE)) && (wr_y < 9'(V_VISIBLE));

   // Position two clocks ahead: the word fetched now is shown from the next 16-pixel boundary.
   always_comb begin
      hn_raw = {1'b0, hcounter} + 12'd2;
      hn     = hn_raw;
      vn     = vcounter;
      if (hn_raw >= 12'(H_TOTAL)) begin
         hn = hn_raw - 12'(H_TOTAL);
         vn = (vcounter == 10'(V_TOTAL - 1)) ? 10'd0 : vcounter + 10'd1;
      end
   end

   assign fetch_vis_nx = (hn < 12'(H_VISIBLE)) && (vn < 10'(V_VISIBLE));
   assign disp_addr    = AW'(vn) * AW'(WPL) + AW'(hn[10:4]);
   assign rmw_addr     = AW'(wy) * AW'(WPL) + AW'(wx[9:4]);

   always_comb begin
      rmw_word          = mem_q;
      rmw_word[wx[3:0]] = wc;
   end

   // Display owns the port in slot 14; RD never issues in 13 so WR never lands in 14.
   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = rmw_addr;
      mem_wdata = 16'd0;
      if (slot14) begin
         mem_re   = fetch_vis_nx;
         mem_addr = disp_addr;
      end else begin
         case (state)
            S_RD:    mem_re = !rd_wait;
            S_WR: begin
               mem_we    = 1'b1;
               mem_wdata = rmw_word;
            end
            S_CLR: begin
               mem_we   = 1'b1;
               mem_addr = clr_addr;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_q <= mem[mem_addr];
   end

   always_comb begin
      state_nx = state;
      wr_ready = 1'b0;
      capture  = 1'b0;
      clr_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (clr_pending) begin
               state_nx = S_CLR;
            end else begin
               wr_ready = 1'b1;
               if (wr_valid && in_range) begin
                  capture  = 1'b1;
                  state_nx = S_RD;
               end else if (clear_req) begin
                  state_nx = S_CLR;
               end
            end
         end
         S_RD:  if (!rd_wait) state_nx = S_WR;
         S_WR:  state_nx = clr_pending ? S_CLR : S_IDLE;
         S_CLR: begin
            if (!slot14 && (clr_addr == AW'(DEPTH - 1))) begin
               clr_done = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         wx          <= '0;
         wy          <= '0;
         wc          <= 1'b0;
         clr_addr    <= '0;
         cur_word    <= '0;
         fetch_vis   <= 1'b0;
`ifdef FB_CLEAR_ON_RESET_EN
         clr_pending <= 1'b1;
`else
         clr_pending <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (capture) begin
            wx <= wr_x;
            wy <= wr_y;
            wc <= wr_color;
         end
         if (clr_done)       clr_pending <= 1'b0;
         else if (clear_req) clr_pending <= 1'b1;
         if (clr_done)
            clr_addr <= '0;
         else if (state == S_CLR && !slot14)
            clr_addr <= clr_addr + AW'(1);
         if (slot14) fetch_vis <= fetch_vis_nx;
         if (slot15) cur_word  <= fetch_vis ? mem_q : 16'd0;
      end
   end

   assign clear_busy = clr_pending;

   always_comb begin
      pixel = 1'b0;
      if ((hcounter < 11'(H_VISIBLE)) && (vcounter < 10'(V_VISIBLE)))
         pixel = cur_word[hcounter[3:0]];
   end

endmodule

// File: doc/pixel_framebuffer.md
Name: pixel_framebuffer

Overview:
- 1-bit-per-pixel 640x480 framebuffer that feeds the `pixel` input of the VGA timing/colour stage.
- Consumes that stage's free-running hcounter/vcounter. Prefetches framebuffer words so that `pixel` always matches the current counter position.
- Accepts pen set/erase writes from the tracking logic through a valid/ready handshake, plus a full-screen clear.
- A single-port word memory is shared between display fetches and write read-modify-write (RMW) cycles.

Parameters:
H_VISIBLE, 640, visible pixels per line (multiple of 16)
V_VISIBLE, 480, visible lines
H_TOTAL, 800, total clocks per line (multiple of 16)
V_TOTAL, 525, total lines per frame

Ports:
clk  in  1  pixel clock, same clock as the VGA stage
reset_n  in  1  asynchronous active-low reset
hcounter  in  11  horizontal counter from the VGA stage
vcounter  in  10  vertical counter from the VGA stage
pixel  out  1  framebuffer bit at (hcounter, vcounter); 0 outside the visible area
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_x  in  10  write column
wr_y  in  9  write row
wr_color  in  1  1 = set bit, 0 = erase bit
clear_req  in  1  single-cycle pulse: zero the entire framebuffer
clear_busy  out  1  high while a clear is pending or running

Behaviour:
- Memory: 16-bit words, H_VISIBLE/16 = 40 words per line, 19200 words total, 15-bit address.
  - Address = y*40 + x[9:4]; bit index = x[3:0]. Bit 0 is the leftmost pixel of the word.
  - Synchronous read: data is available one cycle after the address is issued.
- Display fetch:
  - In every cycle with hcounter[3:0]==14, the memory port is reserved for display.
  - hn = hcounter+2; if hn >= H_TOTAL, then hn -= H_TOTAL and vn = vcounter+1, wrapping at V_TOTAL to 0; otherwise vn = vcounter.
  - Read word (vn, hn[10:4]) when hn < H_VISIBLE and vn < V_VISIBLE; otherwise load 0.
  - The result is registered into cur_word on the edge that ends the hcounter[3:0]==15 cycle.
- Pixel output:
  - pixel = cur_word[hcounter[3:0]] when hcounter < H_VISIBLE and vcounter < V_VISIBLE, else 0.
  - Combinational from cur_word and the counters.
- Write FSM states are IDLE, RD, WR, CLR.
  - IDLE: wr_ready=1. On a handshake, capture x, y and color.
    - Out-of-range coordinates (x >= 640 or y >= 480) are dropped: stay in IDLE, no memory access.
    - Otherwise go to RD.
  - RD: issue the read only when hcounter[3:0] is not 13 or 14; otherwise wait in RD. Next state WR.
  - WR: write the read word with the target bit set or cleared. Return to IDLE, or to CLR if a clear is pending.
  - wr_ready=0 in RD, WR and CLR.
  - Best-case latency: handshake at T, read at T+1, write at T+2, wr_ready high again at T+3.
  - A write lands before the next fetch of its word if it completes before that fetch's cycle-14 slot.
- Clear:
  - clear_req in any state sets clear_pending, and clear_busy goes high the next cycle.
  - An RMW already in flight completes first.
  - clear_req and a write handshake in the same IDLE cycle: the write is accepted and completed, then the clear runs.
  - CLR writes 0 to addresses 0..19199, one per cycle, skipping cycles with hcounter[3:0]==14.
  - After the last write: clear_busy=0, go to IDLE.
  - clear_req while clear_busy=1 is ignored; it does not restart the sweep.
- Reset (asynchronous, reset_n low):
  - state=IDLE, cur_word=0, pixel=0, clear_pending=0, clear_busy=0, wr_ready=1 after release.
  - Memory contents are not reset.
  - Reset asserted mid-RMW or mid-clear aborts it; the partially cleared memory is left as is.
- Counters beyond H_TOTAL/V_TOTAL are never presented; behaviour for them is unspecified.

Optional Feature:
- FB_CLEAR_ON_RESET_EN defined:
  - clear_pending resets to 1, so clear_busy=1 and wr_ready=0 from reset release.
  - A full clear sweep runs automatically, then the block enters IDLE.
- Undefined: memory is undefined after reset until clear_req is issued; the reset values listed above apply.

Test Plan:
- Clear, then write (0,0) set and (639,479) set, then run one frame → pixel=1 exactly at hcounter=0,vcounter=0 and at hcounter=639,vcounter=479; 0 at all other visible positions and in blanking.
- wr_valid held with x=17, y=3 set, then the same coordinate with color=0 → pixel=1 at (17,3) in the frame after the first write, 0 in the frame after the erase. wr_ready is low for 2 cycles per accepted write (more if RD waits).
- Write request issued when hcounter[3:0]==12 → memory read is delayed until hcounter[3:0]==15; no display fetch is corrupted; the neighbouring pixels (16..31, 3) are unchanged.
- Write with x=640 or y=480 → accepted in one cycle, wr_ready stays 1, framebuffer unchanged.
- clear_req pulsed in the same cycle as a write handshake to (5,5) → write completes, clear_busy is 1 for at least 19200 cycles, final frame is all zeros, wr_ready=0 throughout the clear.
- reset_n pulsed low mid-clear → clear_busy=0 immediately, wr_ready=1 after release. With FB_CLEAR_ON_RESET_EN, clear_busy=1 after release and the frame is all zeros afterwards.
